// File: rtl/rvv_wb_collector_pkg.sv
// Shared types and helpers for the vector writeback collector: state codes, element-width codes,
// chunk sizing and per-element activity (tail + v0 mask) evaluation.
package rvv_wb_collector_pkg;

  localparam int IDX_W  = 5;
  localparam int REGI_W = 10;
  localparam int VL_W   = 11;

  typedef enum logic [2:0] {
    VSEW_E8  = 3'd0,
    VSEW_E16 = 3'd1,
    VSEW_E32 = 3'd2,
    VSEW_E64 = 3'd3
  } vsew_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  // A lane chunk never exceeds the lane datapath width, even for wider elements.
  function automatic int chunk_bytes(input logic [2:0] vsew, input int lane_width);
    int lg;
    lg = (int'(vsew) < lane_width - 3) ? int'(vsew) : lane_width - 3;
    return 1 << lg;
  endfunction

  function automatic logic active_elem(input logic [REGI_W-1:0] e, input logic [VL_W-1:0] vl,
                                       input logic vm, input logic v0);
    return ({1'b0, e} < vl) && (vm || v0);
  endfunction

endpackage

// File: rtl/rvv_wb_collector_if.sv
// Writeback bus towards the vector register file: assembled register plus index, valid/ready.
interface rvv_wb_collector_if #(parameter int VLEN = 128) ();
  import rvv_wb_collector_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic [VLEN-1:0]   wb_data;
  logic [IDX_W-1:0]  wb_idx;

  modport master (output wb_valid, output wb_data, output wb_idx, input wb_ready);
  modport slave  (input wb_valid, input wb_data, input wb_idx, output wb_ready);

endinterface

// File: rtl/rvv_wb_lane_merge.sv
// One lane's masked byte merge into the destination buffer; purely combinational,
// chained per lane so a later lane overrides an earlier one on overlapping bytes.
module rvv_wb_lane_merge
  import rvv_wb_collector_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic [VLEN-1:0]   buf_i,
  input  logic [63:0]       lane_vd_i,
  input  logic [REGI_W-1:0] lane_regi_i,
  input  logic              lane_res_i,
  input  logic [2:0]        vsew_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic              vm_i,
  input  logic [VLEN-1:0]   v0_i,
  output logic [VLEN-1:0]   buf_o
);
  localparam int NBYTES = VLEN / 8;
  localparam int VIDX_W = $clog2(VLEN);

  logic [REGI_W-1:0] elem;
  logic              v0_bit;
  logic              wr_en;
  int                cb;

  always_comb begin
    elem   = lane_regi_i >> vsew_i;
    v0_bit = (int'(elem) < VLEN) ? v0_i[elem[VIDX_W-1:0]] : 1'b0;
    cb     = chunk_bytes(vsew_i, LANE_WIDTH);
    wr_en  = lane_res_i && active_elem(elem, vl_i, vm_i, v0_bit);
  end

  // Offsets past the top byte simply never hit, which drops the overhang.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    localparam int BYTE = b;
    logic [2:0] off;
    logic       hit;
    assign off = 3'(BYTE - int'(lane_regi_i));
    assign hit = (BYTE >= int'(lane_regi_i)) && (BYTE < int'(lane_regi_i) + cb);
    assign buf_o[8*b +: 8] = (wr_en && hit) ? lane_vd_i[{off, 3'b000} +: 8] : buf_i[8*b +: 8];
  end

endmodule

// File: rtl/rvv_wb_collector.sv
// Assembles per-lane ALU chunks into a VLEN destination and commits it on a valid/ready bus;
// wb_valid one cycle after alu_done, held with data/index stable while wb_ready is low.
module rvv_wb_collector
  import rvv_wb_collector_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [IDX_W-1:0]            vd_idx_in,
  input  logic [VLEN-1:0]             old_vd,
  input  logic [VLEN-1:0]             v0_mask,
  input  logic                        instr_mask,
  input  logic [2:0]                  vsew,
  input  logic [VL_W-1:0]             vl,
  input  logic [(64<<NB_LANES)-1:0]   lane_vd,
  input  logic [(10<<NB_LANES)-1:0]   lane_regi,
  input  logic [(1<<NB_LANES)-1:0]    lane_res,
  input  logic                        alu_done,
  input  logic                        alu_instr_valid,
  rvv_wb_collector_if.master          wb,
  output logic                        busy,
  output logic                        illegal
);
  localparam int LANES = 1 << NB_LANES;

  state_e             state_q, state_d;
  logic [VLEN-1:0]    buf_q, buf_d;
  logic [VLEN-1:0]    v0_q, v0_d;
  logic               vm_q, vm_d;
  logic [2:0]         vsew_q, vsew_d;
  logic [VL_W-1:0]    vl_q, vl_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               seen_q, seen_d;
  logic               illegal_q, illegal_d;
  int                 vl_lim;

  logic [LANES:0][VLEN-1:0] stage;
  assign stage[0] = buf_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rvv_wb_lane_merge #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH)) u_merge (
      .buf_i       (stage[k]),
      .lane_vd_i   (lane_vd[64*k +: 64]),
      .lane_regi_i (lane_regi[10*k +: 10]),
      .lane_res_i  (lane_res[k]),
      .vsew_i      (vsew_q),
      .vl_i        (vl_q),
      .vm_i        (vm_q),
      .v0_i        (v0_q),
      .buf_o       (stage[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      buf_q     <= '0;
      v0_q      <= '0;
      vm_q      <= 1'b0;
      vsew_q    <= '0;
      vl_q      <= '0;
      idx_q     <= '0;
      seen_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      v0_q      <= v0_d;
      vm_q      <= vm_d;
      vsew_q    <= vsew_d;
      vl_q      <= vl_d;
      idx_q     <= idx_d;
      seen_q    <= seen_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    v0_d      = v0_q;
    vm_d      = vm_q;
    vsew_d    = vsew_q;
    vl_d      = vl_q;
    idx_d     = idx_q;
    seen_d    = seen_q;
    illegal_d = 1'b0;
    vl_lim    = VLEN >> (int'(vsew) + 3);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_d   = old_vd;
          v0_d    = v0_mask;
          vm_d    = instr_mask;
          vsew_d  = vsew;
          vl_d    = (int'(vl) > vl_lim) ? VL_W'(vl_lim) : vl;
          idx_d   = vd_idx_in;
          seen_d  = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        buf_d  = stage[LANES];
        seen_d = seen_q | alu_instr_valid;
        // An opcode the ALU never accepted is dropped without touching the register file.
        if (alu_done) begin
          if (seen_d) begin
            state_d = ST_COMMIT;
          end else begin
            state_d   = ST_IDLE;
            illegal_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        if (wb.wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb.wb_valid = (state_q == ST_COMMIT);
  assign wb.wb_data  = buf_q;
  assign wb.wb_idx   = idx_q;
  assign busy        = (state_q != ST_IDLE);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_rvv_wb_collector.sv
// Randomized and directed bench for rvv_wb_collector with a byte-array reference model.
module tb_rvv_wb_collector;
  localparam int VLEN   = 128;
  localparam int LW     = 3;
  localparam int LANES  = 2;
  localparam int NBYTES = VLEN / 8;

  logic          clk = 1'b0;
  logic          resetn, start, instr_mask, alu_done, alu_instr_valid;
  logic [4:0]    vd_idx_in;
  logic [127:0]  old_vd, v0_mask, lane_vd;
  logic [2:0]    vsew;
  logic [10:0]   vl;
  logic [19:0]   lane_regi;
  logic [1:0]    lane_res;
  logic          busy, illegal;

  always #5 clk = ~clk;

  rvv_wb_collector_if #(.VLEN(VLEN)) wb_if ();

  rvv_wb_collector #(.VLEN(VLEN), .LANE_WIDTH(LW), .NB_LANES(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vd_idx_in(vd_idx_in), .old_vd(old_vd),
    .v0_mask(v0_mask), .instr_mask(instr_mask), .vsew(vsew), .vl(vl), .lane_vd(lane_vd),
    .lane_regi(lane_regi), .lane_res(lane_res), .alu_done(alu_done),
    .alu_instr_valid(alu_instr_valid), .wb(wb_if), .busy(busy), .illegal(illegal)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 waiting for commit.
  int           m_phase = 0;
  logic [7:0]   m_bytes [NBYTES];
  logic [127:0] m_v0;
  bit           m_vm, m_seen, m_illegal = 0, m_fresh = 1;
  int           m_vsew, m_vl, m_idx = 0;
  int           regi, cb, e, lim, vlc;

  function automatic logic [127:0] model_data();
    logic [127:0] d;
    for (int i = 0; i < NBYTES; i++) d[8*i +: 8] = m_bytes[i];
    return d;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_phase = 0; m_idx = 0; m_illegal = 0; m_fresh = 1;
      for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;
    end else begin
      m_illegal = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_v0 = v0_mask; m_vm = instr_mask; m_vsew = int'(vsew); m_vl = int'(vl);
          m_idx = int'(vd_idx_in); m_seen = 0; m_fresh = 0; m_phase = 1;
          for (int i = 0; i < NBYTES; i++) m_bytes[i] = old_vd[8*i +: 8];
        end
      end else if (m_phase == 1) begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_res[k]) begin
            regi = int'(lane_regi[10*k +: 10]);
            cb   = 1 << ((m_vsew < LW - 3) ? m_vsew : LW - 3);
            e    = regi >> m_vsew;
            lim  = VLEN >> (m_vsew + 3);
            vlc  = (m_vl > lim) ? lim : m_vl;
            if (e < vlc && (m_vm || (e < VLEN && m_v0[e])))
              for (int j = 0; j < cb; j++)
                if (regi + j < NBYTES) m_bytes[regi + j] = lane_vd[64*k + 8*j +: 8];
          end
        end
        if (alu_instr_valid) m_seen = 1;
        if (alu_done) begin
          if (m_seen) m_phase = 2;
          else begin m_phase = 0; m_illegal = 1; end
        end
      end else if (wb_if.wb_ready) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_phase != 0);
      check("wb_valid", wb_if.wb_valid, m_phase == 2);
      check("illegal", illegal, m_illegal);
      if (m_phase == 2 || m_fresh) begin
        check("wb_data", wb_if.wb_data, model_data());
        check("wb_idx", wb_if.wb_idx, 128'(m_idx));
      end
    end
  end

  task automatic begin_instr(input int idx, input logic [127:0] old, input logic [127:0] v0,
                             input bit vm, input int sew, input int vlen);
    vd_idx_in = 5'(idx); old_vd = old; v0_mask = v0; instr_mask = vm;
    vsew = 3'(sew); vl = 11'(vlen); start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Two lanes per cycle deliver byte offset i with value i+1.
  task automatic feed(input int ncyc, input bit ivalid, input bit done);
    for (int c = 0; c < ncyc; c++) begin
      lane_vd   = {56'd0, 8'(2*c + 2), 56'd0, 8'(2*c + 1)};
      lane_regi = {10'(2*c + 1), 10'(2*c)};
      lane_res  = 2'b11;
      alu_instr_valid = ivalid && (c == ncyc / 2);
      alu_done  = done && (c == ncyc - 1);
      @(negedge clk);
    end
    lane_res = 0; alu_done = 0; alu_instr_valid = 0;
  endtask

  localparam logic [127:0] SEQ16 = 128'h100F0E0D0C0B0A090807060504030201;

  initial begin
    int cnt, ncyc;
    bit allow;
    resetn = 0; start = 0; vd_idx_in = 0; old_vd = 0; v0_mask = 0; instr_mask = 1;
    vsew = 0; vl = 0; lane_vd = 0; lane_regi = 0; lane_res = 0; alu_done = 0;
    alu_instr_valid = 0; wb_if.wb_ready = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_busy", busy, 0);
    check("rst_valid", wb_if.wb_valid, 0);
    check("rst_data", wb_if.wb_data, 0);
    resetn = 1;

    begin_instr(5, {16{8'hFF}}, 0, 1, 0, 16);
    feed(8, 1, 1);
    check("unmasked_latency", wb_if.wb_valid, 1);
    check("unmasked_data", wb_if.wb_data, SEQ16);
    check("unmasked_idx", wb_if.wb_idx, 5);
    @(negedge clk);
    check("unmasked_idle", busy, 0);

    begin_instr(9, {16{8'hAA}}, 128'h00FF, 0, 0, 16);
    feed(8, 1, 1);
    check("masked_data", wb_if.wb_data, 128'hAAAAAAAAAAAAAAAA0807060504030201);
    @(negedge clk);

    begin_instr(12, {16{8'h55}}, 0, 1, 2, 2);
    feed(8, 1, 1);
    check("tail_data", wb_if.wb_data, 128'h55555555555555550807060504030201);
    @(negedge clk);

    begin_instr(6, {16{8'h3C}}, 0, 1, 0, 0);
    feed(8, 1, 1);
    check("vl0_data", wb_if.wb_data, {16{8'h3C}});
    @(negedge clk);

    wb_if.wb_ready = 0;
    begin_instr(3, {16{8'h11}}, 0, 1, 0, 16);
    feed(8, 1, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", wb_if.wb_valid, 1);
      check("bp_data", wb_if.wb_data, SEQ16);
      check("bp_idx", wb_if.wb_idx, 3);
      check("bp_busy", busy, 1);
      start = (i == 2); vd_idx_in = 7; old_vd = 0;
      @(negedge clk);
    end
    start = 0;
    wb_if.wb_ready = 1;
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_valid", wb_if.wb_valid, 0);

    begin_instr(4, {16{8'h99}}, 0, 1, 0, 16);
    feed(8, 0, 1);
    check("illegal_pulse", illegal, 1);
    check("illegal_busy", busy, 0);
    check("illegal_valid", wb_if.wb_valid, 0);
    @(negedge clk);
    check("illegal_once", illegal, 0);

    begin_instr(8, {16{8'h77}}, 0, 1, 0, 16);
    feed(3, 1, 0);
    resetn = 0;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", wb_if.wb_valid, 0);
    resetn = 1;
    begin_instr(10, {16{8'h22}}, 0, 1, 0, 8);
    feed(8, 1, 1);
    check("rstmid_data", wb_if.wb_data, 128'h22222222222222220807060504030201);
    @(negedge clk);

    for (int t = 0; t < 200; t++) begin
      wb_if.wb_ready = 1'($urandom_range(0, 1));
      begin_instr($urandom_range(0, 31), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 40));
      ncyc  = $urandom_range(1, 6);
      allow = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < ncyc; c++) begin
        lane_vd   = {$urandom, $urandom, $urandom, $urandom};
        lane_regi = {10'($urandom_range(0, 20)), 10'($urandom_range(0, 20))};
        lane_res  = 2'($urandom_range(0, 3));
        alu_instr_valid = allow && ($urandom_range(0, 1) == 1);
        alu_done  = (c == ncyc - 1);
        start     = ($urandom_range(0, 7) == 0);
        vd_idx_in = 5'($urandom_range(0, 31));
        old_vd    = {$urandom, $urandom, $urandom, $urandom};
        wb_if.wb_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      lane_res = 0; alu_done = 0; alu_instr_valid = 0;
      cnt = 0;
      while (busy && cnt < 60) begin
        wb_if.wb_ready = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        cnt++;
      end
      start = 0;
      check("rand_drain", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule

// File: doc/rvv_wb_collector.md
Name: rvv_wb_collector

Overview:
- Sits directly downstream of the multi-lane vector ALU wrapper.
- Collects per-lane partial results (data, byte offset, lane-valid) chunk by chunk into a VLEN-bit destination buffer, applying v0 masking and tail/mask-undisturbed policy.
- When the ALU signals completion, presents the assembled register to the vector register file with a valid/ready handshake.
- Frees the ALU run slot for the next instruction as soon as commit is accepted.

Parameters:
- VLEN, 128, vector register width in bits (multiple of 64).
- LANE_WIDTH, 3, log2 of lane chunk width in bits (3 = 8-bit chunks, max 6).
- NB_LANES, 1, log2 of the number of ALU lanes; lanes = 1<<NB_LANES, max 8.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: latch instruction context, begin collection
- vd_idx_in  in  5  destination register index
- old_vd  in  VLEN  current destination contents (undisturbed source)
- v0_mask  in  VLEN  mask register v0
- instr_mask  in  1  vm bit; 1 = unmasked, 0 = use v0
- vsew  in  3  element width code (0=e8 .. 3=e64)
- vl  in  11  active element count
- lane_vd  in  64<<NB_LANES  per-lane result data, lane k at [64k+:64]
- lane_regi  in  10<<NB_LANES  per-lane byte offset in destination, lane k at [10k+:10]
- lane_res  in  1<<NB_LANES  per-lane write enable
- alu_done  in  1  ALU wrapper done pulse
- alu_instr_valid  in  1  ALU accepted opcode
- wb_valid  out  1  assembled register ready for writeback
- wb_ready  in  1  register file accepts writeback
- wb_data  out  VLEN  assembled destination value
- wb_idx  out  5  destination index
- busy  out  1  high in any state except IDLE
- illegal  out  1  one-cycle pulse: opcode rejected, nothing committed

Behaviour:
- Reset: state=IDLE; wb_valid=0, busy=0, illegal=0; wb_data=0, wb_idx=0; internal buffer and context cleared.
- State IDLE, on start:
  - latch old_vd into buffer, plus v0_mask, instr_mask, vsew, vl, vd_idx_in;
  - go to COLLECT next cycle.
  - start while not IDLE is ignored.
- State COLLECT, each cycle, for every lane k with lane_res[k]=1:
  - CB = 1<<min(vsew, LANE_WIDTH-3) bytes;
  - element e = lane_regi[k] >> vsew;
  - write byte range [regi, regi+CB) with low 8*CB bits of lane_vd[k] only if e < vl and (instr_mask or v0_mask[e]);
  - otherwise the buffer keeps its byte (undisturbed).
  - Bytes beyond VLEN are dropped.
  - Lanes write disjoint bytes; on overlap, the higher lane index wins.
- COLLECT exit:
  - Writes in the alu_done cycle are applied.
  - Next cycle go to COMMIT if alu_instr_valid=1 was sampled at any COLLECT cycle.
  - Otherwise pulse illegal and return to IDLE.
- State COMMIT: wb_valid=1; wb_data=buffer and wb_idx held stable until wb_ready. On wb_valid&&wb_ready, go to IDLE next cycle and deassert wb_valid.
- Latency: alu_done at cycle N -> wb_valid at N+1. wb_ready may already be high, giving commit at N+1.
- vl=0: ALU still pulses alu_done; no bytes change; wb_data=old_vd.
- vl > VLEN>>(vsew+3): clipped to VLEN>>(vsew+3).
- resetn low in any state: immediate return to reset values next edge; no partial commit.

Decomposition:
- Shared rvv package:
  - VSEW codes;
  - state encodings IDLE/COLLECT/COMMIT;
  - function chunk_bytes(vsew, LANE_WIDTH);
  - function active_elem(e, vl, vm, v0).
- One sub-module, rvv_wb_lane_merge: single-lane byte-enable generation and masked merge. Instantiated per lane in a generate loop; merged in lane order.

Test Plan:
- Unmasked e8, VLEN=128, NB_LANES=1, vl=16, lanes deliver byte i = i+1 at regi 0..15, old_vd all 0xFF -> wb_data bytes 0x01..0x10, wb_idx matches, wb_valid at alu_done+1.
- Masked e8, instr_mask=0, v0=0x00FF, vl=16, old_vd=0xAA.. -> bytes 0-7 new, bytes 8-15 stay 0xAA.
- Tail e32, LANE_WIDTH=3, vl=2, four chunks per element -> bytes 0-7 written, bytes 8-15 equal old_vd.
- Backpressure: wb_ready low 5 cycles after wb_valid -> wb_data/wb_idx stable, busy=1; start pulse ignored; commit on first ready cycle, IDLE next.
- alu_instr_valid never high -> illegal pulses once, wb_valid stays 0, busy drops next cycle.
- resetn low mid-COLLECT -> busy=0, wb_valid=0 next cycle; following start collects cleanly from new old_vd.
